vga_window_buffer: RTL and testbench

Parametrised VGA-to-window front end: accepts RGB pixels qualified by VGA data-enable/sync strobes on a single system clock, converts them to grayscale, buffers the last N−1 active lines and emits every complete N×N grayscale window with its top-left frame coordinate. It sits between the VGA capture input and the edge-detection kernels. It supersedes the fixed 3×3 colorspace converter with configurable window size, configurable grayscale mode, frame-boundary tracking and error reporting.

---
 rtl/vga_window_buffer.sv | 168 ++++++++++++++++
 tb/tb_vga_window_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_window_buffer.sv
// VGA RGB stream to grayscale N x N sliding windows with frame coordinates.
// Three stages: input capture, grayscale, then line buffers and window.
module vga_window_buffer #(
  parameter int P_FRAME_COLUMNS = 640,
  parameter int P_FRAME_ROWS    = 480,
  parameter int P_PIXEL_DEPTH   = 24,
  parameter int P_WINDOW_SIZE   = 3,
  parameter int P_GRAY_MODE     = 0
) (
  input  logic I_CLK,
  input  logic I_RESET,
  input  logic I_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
  input  logic I_VSYNC,
  input  logic I_HSYNC,
  input  logic I_DATA_ENABLE,
  output logic [$clog2(P_FRAME_COLUMNS)-1:0] O_PIXEL_COL,
  output logic [$clog2(P_FRAME_ROWS)-1:0] O_PIXEL_ROW,
  output logic [P_WINDOW_SIZE*P_WINDOW_SIZE*(P_PIXEL_DEPTH/3)-1:0] O_PIXEL_MATRIX,
  output logic O_PIXEL_MATRIX_READY,
  output logic O_FRAME_DONE,
  output logic O_ERROR
);
  localparam int S  = P_PIXEL_DEPTH / 3;
  localparam int N  = P_WINDOW_SIZE;
  localparam int L  = N - 1;
  localparam int CW = $clog2(P_FRAME_COLUMNS);
  localparam int RW = $clog2(P_FRAME_ROWS);
  localparam int CI = $clog2(P_FRAME_COLUMNS + 1);
  localparam int RI = $clog2(P_FRAME_ROWS + 1);
  localparam int PW = $clog2(L);
  localparam int MW = N * N * S;

  logic [CI-1:0] col_in;
  logic [RI-1:0] row_in;
  logic de_q;
  logic s0_valid, s0_eol;
  logic [P_PIXEL_DEPTH-1:0] s0_pix;
  logic [CI-1:0] s0_col;
  logic [RI-1:0] s0_row;
  logic s1_valid, s1_eol;
  logic [S-1:0] s1_gray;
  logic [CI-1:0] s1_col;
  logic [RI-1:0] s1_row;
  logic [PW-1:0] ptr;
  logic [S-1:0] lb [L][P_FRAME_COLUMNS];
  logic [S-1:0] win [N][N];
  logic [S-1:0] win_next [N][N];
  logic [MW-1:0] mat_next;
  logic [S-1:0] red, grn, blu, gray;
  logic [S+1:0] sum0;
  logic [S+7:0] sum1;
  logic accept, in_range, line_end;
  logic proc, wvalid, last;

  assign red  = s0_pix[3*S-1:2*S];
  assign grn  = s0_pix[2*S-1:S];
  assign blu  = s0_pix[S-1:0];
  assign sum0 = (S+2)'(red) + (S+2)'({grn, 1'b0}) + (S+2)'(blu);
  assign sum1 = (S+8)'(red) * (S+8)'(77)
              + (S+8)'(grn) * (S+8)'(150)
              + (S+8)'(blu) * (S+8)'(29);
  assign gray = (P_GRAY_MODE == 1) ? S'(sum1 >> 8) : S'(sum0 >> 2);

  assign accept   = I_ENABLE && I_DATA_ENABLE && !I_VSYNC;
  assign in_range = (col_in < CI'(P_FRAME_COLUMNS))
                 && (row_in < RI'(P_FRAME_ROWS));
  assign line_end = I_ENABLE && de_q && !I_DATA_ENABLE && !I_VSYNC;
  assign proc     = s1_valid && !I_VSYNC;
  assign wvalid   = (s1_col >= CI'(L)) && (s1_row >= RI'(L));
  assign last     = (s1_col == CI'(P_FRAME_COLUMNS - 1))
                 && (s1_row == RI'(P_FRAME_ROWS - 1));

  // Buffered rows are read oldest first, starting at the rotation pointer.
  always_comb begin
    int k;
    win_next = win;
    mat_next = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N - 1; c++) win_next[r][c] = win[r][c+1];
      k = int'(ptr) + r;
      if (k >= L) k = k - L;
      if (r == N - 1) win_next[r][N-1] = s1_gray;
      else win_next[r][N-1] = lb[PW'(k)][CW'(s1_col)];
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat_next[(r*N+c)*S +: S] = win_next[r][c];
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      col_in   <= '0;
      row_in   <= '0;
      de_q     <= 1'b0;
      s0_valid <= 1'b0;
      s0_eol   <= 1'b0;
      s0_pix   <= '0;
      s0_col   <= '0;
      s0_row   <= '0;
      s1_valid <= 1'b0;
      s1_eol   <= 1'b0;
      s1_gray  <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
      O_ERROR  <= 1'b0;
    end else if (I_ENABLE) begin
      de_q     <= I_DATA_ENABLE && !I_VSYNC;
      s0_valid <= accept && in_range;
      s0_eol   <= line_end;
      s0_pix   <= I_PIXEL;
      s0_col   <= col_in;
      s0_row   <= row_in;
      s1_valid <= s0_valid && !I_VSYNC;
      s1_eol   <= s0_eol && !I_VSYNC;
      s1_gray  <= gray;
      s1_col   <= s0_col;
      s1_row   <= s0_row;
      if (I_VSYNC) begin
        col_in <= '0;
        row_in <= '0;
      end else if (line_end) begin
        col_in <= '0;
        if (row_in != RI'(P_FRAME_ROWS)) row_in <= row_in + RI'(1);
      end else if (accept && in_range) begin
        col_in <= col_in + CI'(1);
      end
      if ((accept && !in_range) || (I_HSYNC && I_DATA_ENABLE))
        O_ERROR <= 1'b1;
    end
  end

  // Rotation follows the line-end marker down the pipe so the last
  // pixel of a line is still written into the line it belongs to.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      ptr                  <= '0;
      win                  <= '{default: '0};
      O_PIXEL_COL          <= '0;
      O_PIXEL_ROW          <= '0;
      O_PIXEL_MATRIX       <= '0;
      O_PIXEL_MATRIX_READY <= 1'b0;
      O_FRAME_DONE         <= 1'b0;
    end else if (I_ENABLE) begin
      O_PIXEL_MATRIX_READY <= 1'b0;
      O_FRAME_DONE         <= 1'b0;
      if (I_VSYNC) ptr <= '0;
      else if (s1_eol) ptr <= (ptr == PW'(L - 1)) ? '0 : ptr + PW'(1);
      if (proc) begin
        win <= win_next;
        if (wvalid) begin
          O_PIXEL_MATRIX_READY <= 1'b1;
          O_FRAME_DONE         <= last;
          O_PIXEL_COL          <= CW'(s1_col - CI'(L));
          O_PIXEL_ROW          <= RW'(s1_row - RI'(L));
          O_PIXEL_MATRIX       <= mat_next;
        end
      end
    end else begin
      O_PIXEL_MATRIX_READY <= 1'b0;
      O_FRAME_DONE         <= 1'b0;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_ENABLE && proc) lb[ptr][CW'(s1_col)] <= s1_gray;
  end
endmodule

// File: tb/tb_vga_window_buffer.sv
// Bench for vga_window_buffer: three instances (N=3 mode 0, N=3 mode 1,
// N=5 mode 0) on an 8x6 frame checked against a frame-array window model.
module tb_vga_window_buffer;
  localparam int C = 8;
  localparam int R = 6;

  logic clk = 0, rst = 0, en = 0, vs = 0, hs = 0, de = 0;
  logic [23:0] px = '0;

  logic [2:0] c3, r3, c1, r1, c5, r5;
  logic [71:0] m3, m1;
  logic [199:0] m5;
  logic rd3, rd1, rd5, d3, d1, d5, e3, e1, e5;

  always #5 clk = ~clk;

  vga_window_buffer #(.P_FRAME_COLUMNS(C), .P_FRAME_ROWS(R),
    .P_PIXEL_DEPTH(24), .P_WINDOW_SIZE(3), .P_GRAY_MODE(0)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_PIXEL(px),
    .I_VSYNC(vs), .I_HSYNC(hs), .I_DATA_ENABLE(de),
    .O_PIXEL_COL(c3), .O_PIXEL_ROW(r3), .O_PIXEL_MATRIX(m3),
    .O_PIXEL_MATRIX_READY(rd3), .O_FRAME_DONE(d3), .O_ERROR(e3));

  vga_window_buffer #(.P_FRAME_COLUMNS(C), .P_FRAME_ROWS(R),
    .P_PIXEL_DEPTH(24), .P_WINDOW_SIZE(3), .P_GRAY_MODE(1)) dut1 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_PIXEL(px),
    .I_VSYNC(vs), .I_HSYNC(hs), .I_DATA_ENABLE(de),
    .O_PIXEL_COL(c1), .O_PIXEL_ROW(r1), .O_PIXEL_MATRIX(m1),
    .O_PIXEL_MATRIX_READY(rd1), .O_FRAME_DONE(d1), .O_ERROR(e1));

  vga_window_buffer #(.P_FRAME_COLUMNS(C), .P_FRAME_ROWS(R),
    .P_PIXEL_DEPTH(24), .P_WINDOW_SIZE(5), .P_GRAY_MODE(0)) dut5 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_PIXEL(px),
    .I_VSYNC(vs), .I_HSYNC(hs), .I_DATA_ENABLE(de),
    .O_PIXEL_COL(c5), .O_PIXEL_ROW(r5), .O_PIXEL_MATRIX(m5),
    .O_PIXEL_MATRIX_READY(rd5), .O_FRAME_DONE(d5), .O_ERROR(e5));

  typedef struct {
    int t;
    int col;
    int row;
    logic [199:0] m;
    bit done;
  } win_t;

  win_t q [3][$];
  int ecyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int npulse [3] = '{default: 0};
  int ndone [3] = '{default: 0};
  int b [3];
  int bd [3];
  logic [199:0] first [3];
  logic [23:0] img [R][C];
  int g [2][R][C];

  always @(posedge clk) if (en) ecyc <= ecyc + 1;

  task automatic cmp(string tag, logic [199:0] got, logic [199:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk(int k, logic rdy, int col, int row,
                     logic [199:0] m, logic dn);
    win_t e;
    if (rdy) begin
      npulse[k]++;
      if (dn) ndone[k]++;
      if (col == 0 && row == 0) first[k] = m;
      if (q[k].size() == 0) begin
        cmp($sformatf("d%0d_spurious_ready", k), 200'(rdy), 0);
      end else begin
        e = q[k].pop_front();
        cmp($sformatf("d%0d_latency", k), ecyc, e.t);
        cmp($sformatf("d%0d_col", k), col, e.col);
        cmp($sformatf("d%0d_row", k), row, e.row);
        cmp($sformatf("d%0d_matrix", k), m, e.m);
        cmp($sformatf("d%0d_done", k), 200'(dn), 200'(e.done));
      end
    end else if (q[k].size() > 0 && q[k][0].t <= ecyc) begin
      cmp($sformatf("d%0d_missing_ready", k), 200'(rdy), 1);
      void'(q[k].pop_front());
    end
  endtask

  always @(negedge clk) begin
    chk(0, rd3, int'(c3), int'(r3), 200'(m3), d3);
    chk(1, rd1, int'(c1), int'(r1), 200'(m1), d1);
    chk(2, rd5, int'(c5), int'(r5), m5, d5);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int k, int r, int c);
    int n;
    int md;
    win_t e;
    n = (k == 2) ? 5 : 3;
    md = (k == 1) ? 1 : 0;
    if (c >= n - 1 && r >= n - 1) begin
      e.t = ecyc + 3;
      e.col = c - n + 1;
      e.row = r - n + 1;
      e.done = (e.col == C - n) && (e.row == R - n);
      e.m = '0;
      for (int rr = 0; rr < n; rr++)
        for (int cc = 0; cc < n; cc++)
          e.m[(rr*n+cc)*8 +: 8] = 8'(g[md][e.row+rr][e.col+cc]);
      q[k].push_back(e);
    end
  endtask

  task automatic pix(int r, int c, logic [23:0] p, bit keep);
    int rv, gv, bv;
    en = 1; de = 1; px = p;
    if (keep) begin
      rv = int'(p[23:16]); gv = int'(p[15:8]); bv = int'(p[7:0]);
      g[0][r][c] = (rv + 2 * gv + bv) / 4;
      g[1][r][c] = (77 * rv + 150 * gv + 29 * bv) / 256;
      for (int k = 0; k < 3; k++) push(k, r, c);
    end
    tick();
  endtask

  task automatic line(int r, int n, int gapat);
    for (int c = 0; c < n; c++) begin
      if (c == gapat) begin
        en = 0; px = 24'hABCDEF;
        repeat (3) begin
          tick();
          cmp("gap_ready_n3", 200'(rd3), 0);
          cmp("gap_ready_n5", 200'(rd5), 0);
        end
      end
      if (c < C) pix(r, c, img[r][c], 1);
      else pix(r, c, 24'($urandom()), 0);
    end
    de = 0; hs = 1; px = '0;
    tick();
    hs = 0;
    tick();
    tick();
  endtask

  task automatic vsync();
    en = 1; de = 0; vs = 1;
    tick();
    vs = 0;
    tick();
  endtask

  task automatic frame(int gaprow, int longrow);
    vsync();
    for (int r = 0; r < R; r++)
      line(r, (r == longrow) ? C + 1 : C, (r == gaprow) ? 4 : -1);
  endtask

  task automatic rand_img();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) img[r][c] = 24'($urandom());
  endtask

  task automatic snap();
    for (int k = 0; k < 3; k++) begin
      b[k] = npulse[k];
      bd[k] = ndone[k];
    end
  endtask

  task automatic counts(string tag);
    cmp({tag, "_pulses_n3m0"}, npulse[0] - b[0], 24);
    cmp({tag, "_pulses_n3m1"}, npulse[1] - b[1], 24);
    cmp({tag, "_pulses_n5"}, npulse[2] - b[2], 8);
    for (int k = 0; k < 3; k++)
      cmp($sformatf("%s_frame_done_d%0d", tag, k), ndone[k] - bd[k], 1);
  endtask

  task automatic zero_chk(string tag);
    cmp({tag, "_col"}, 200'(c3), 0);
    cmp({tag, "_row"}, 200'(r3), 0);
    cmp({tag, "_matrix"}, 200'(m3), 0);
    cmp({tag, "_matrix_n5"}, m5, 0);
    cmp({tag, "_ready"}, 200'(rd3), 0);
    cmp({tag, "_done"}, 200'(d3), 0);
    cmp({tag, "_error"}, 200'(e3), 0);
  endtask

  initial begin
    logic [199:0] f;
    rst = 1;
    tick();
    tick();
    zero_chk("reset");
    rst = 0;
    tick();

    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) img[r][c] = {3{8'(r * 8 + c)}};
    snap();
    frame(3, -1);
    counts("ramp");
    f = first[0];
    cmp("ramp_m00", 200'(f[7:0]), 0);
    cmp("ramp_m22", 200'(f[71:64]), 18);
    f = first[2];
    cmp("ramp_n5_toprow", 200'(f[39:0]), 200'(40'h0403020100));

    rand_img();
    img[0][0] = 24'hFF0000;
    img[0][1] = 24'hFFFFFF;
    snap();
    frame(-1, -1);
    counts("rand1");
    f = first[1];
    cmp("mode1_red", 200'(f[7:0]), 76);
    cmp("mode1_white", 200'(f[15:8]), 255);
    f = first[0];
    cmp("mode0_red", 200'(f[7:0]), 63);
    cmp("no_error", 200'(e3), 0);

    rand_img();
    snap();
    frame(-1, 1);
    counts("overlong");
    cmp("overlong_error", 200'(e3), 1);

    rand_img();
    vsync();
    cmp("error_sticky_vsync", 200'(e3), 1);
    for (int r = 0; r < 4; r++) line(r, C, -1);
    for (int c = 0; c < 3; c++) pix(4, c, img[4][c], 1);
    rst = 1;
    #1;
    zero_chk("midrst");
    for (int k = 0; k < 3; k++) q[k].delete();
    de = 0;
    tick();
    tick();
    rst = 0;
    tick();

    rand_img();
    snap();
    frame(-1, -1);
    counts("after_rst");
    for (int k = 0; k < 3; k++)
      cmp($sformatf("drained_d%0d", k), q[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
